tile_sequencer: RTL

- Upstream instruction generator for the dual-corelet core.
- After a start pulse, runs one tiled convolution pass over KIJ kernel positions.
- Drives the 34-bit instruction word plus mode/sel/tile/relu sideband, cycle by cycle: weight L0 fill, weight load, activation execute, OFIFO drain into psum SRAM with accumulation.
- Paces drain on the core's ofifo_valid.

---
 rtl/tile_sequencer_if.sv | 18 +
 rtl/tile_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tile_sequencer_if.sv
// Core-side bus of the tile sequencer.
//   inst        : 34-bit instruction word presented to the dual-corelet core
//   mode, relu  : pass-wide config copies (precision mode, ReLU enable)
//   tile        : corelet enable mask
//   sel         : psum bank currently being written
//   ofifo_valid : core OFIFO holds a row ready to drain
// master = sequencer side, slave = core side.
interface tile_sequencer_if;
  logic [33:0] inst;
  logic        mode;
  logic        relu;
  logic [1:0]  tile;
  logic        sel;
  logic        ofifo_valid;

  modport master (output inst, mode, relu, tile, sel, input ofifo_valid);
  modport slave  (input inst, mode, relu, tile, sel, output ofifo_valid);
endinterface

// File: rtl/tile_sequencer.sv
// Instruction sequencer for one tiled convolution pass over cfg_kij kernel
// positions. Per kernel position: weight L0 fill, weight load, wavefront
// gap, activation execute, then OFIFO drain into psum SRAM (accumulating
// from the second kernel position on). All outputs are registered.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start               : one-cycle pulse, accepted only when idle
//   cfg_w/x/p_base      : xmem weight/activation bases, pmem output base
//   cfg_nij, cfg_kij    : output pixels per kernel position, kernel positions
//   cfg_tile/mode/relu  : latched and forwarded on the core bus
//   cfg_sel0            : initial psum write bank
//   core                : instruction word + sideband, ofifo_valid back
//   busy, done          : pass in progress, one-cycle end-of-pass pulse
module tile_sequencer #(
  parameter int row     = 2,
  parameter int col     = 2,
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] cfg_w_base,
  input  logic [addr_bw-1:0] cfg_x_base,
  input  logic [addr_bw-1:0] cfg_p_base,
  input  logic [cnt_bw-1:0]  cfg_nij,
  input  logic [cnt_bw-1:0]  cfg_kij,
  input  logic [1:0]         cfg_tile,
  input  logic               cfg_mode,
  input  logic               cfg_relu,
  input  logic               cfg_sel0,
  tile_sequencer_if.master   core,
  output logic               busy,
  output logic               done
);
  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;
  // One extra bit so the execute counter can reach nij+row+col.
  localparam int CW = cnt_bw + 1;
  localparam logic [CW-1:0] FILL_LAST = CW'(row - 1);
  localparam logic [CW-1:0] WAVE_LAST = CW'(row + col - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WFILL, S_WLOAD, S_WGAP, S_XEXEC, S_DRAIN, S_DONE
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [cnt_bw-1:0]  kij_cnt;
  logic [cnt_bw-1:0]  nij_r;
  logic [cnt_bw-1:0]  kij_r;
  logic [addr_bw-1:0] w_base_r;
  logic [addr_bw-1:0] x_base_r;
  logic [addr_bw-1:0] p_base_r;
  logic               flip_pending;

  logic [CW-1:0]      nij_ext;
  logic [CW-1:0]      exec_last;
  logic [addr_bw-1:0] w_addr;
  logic [addr_bw-1:0] x_addr;
  logic [addr_bw-1:0] p_addr;
  logic               last_write;
  logic               last_kij;
  logic [33:0]        inst_nxt;

  function automatic logic [33:0] xmem_read(input logic [addr_bw-1:0] a);
    logic [33:0] w;
    w       = IDLE_INST;
    w[19]   = 1'b0;
    w[17:7] = 11'(a);
    return w;
  endfunction

  function automatic logic [33:0] pmem_write(input logic [addr_bw-1:0] a,
                                             input logic acc);
    logic [33:0] w;
    w        = IDLE_INST;
    w[33]    = acc;
    w[32]    = 1'b0;
    w[31]    = 1'b0;
    w[30:20] = 11'(a);
    w[6]     = 1'b1;
    return w;
  endfunction

  always_comb begin
    nij_ext    = {1'b0, nij_r};
    exec_last  = nij_ext + CW'(row + col);
    // kij*row is taken modulo 2^addr_bw, so truncating both factors first is exact.
    w_addr     = w_base_r + addr_bw'(kij_cnt) * addr_bw'(row) + addr_bw'(cnt);
    x_addr     = x_base_r + addr_bw'(cnt);
    p_addr     = p_base_r + addr_bw'(cnt);
    last_write = (cnt == nij_ext - 1'b1);
    last_kij   = (kij_cnt == kij_r - 1'b1);
    inst_nxt   = IDLE_INST;
    case (state)
      S_WFILL: begin
        inst_nxt    = xmem_read(w_addr);
        // xmem data arrives one cycle after its address
        inst_nxt[2] = (cnt != '0);
      end
      S_WLOAD: begin
        inst_nxt[0] = 1'b1;
        inst_nxt[3] = 1'b1;
        // trailing L0 write of the last fill address
        inst_nxt[2] = (cnt == '0);
      end
      S_XEXEC: begin
        if (cnt < nij_ext) inst_nxt = xmem_read(x_addr);
        if (cnt != '0) begin
          inst_nxt[1] = 1'b1;
          inst_nxt[3] = 1'b1;
          inst_nxt[2] = (cnt <= nij_ext);
        end
      end
      S_DRAIN: begin
        if (core.ofifo_valid) inst_nxt = pmem_write(p_addr, kij_cnt != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      kij_cnt      <= '0;
      nij_r        <= '0;
      kij_r        <= '0;
      w_base_r     <= '0;
      x_base_r     <= '0;
      p_base_r     <= '0;
      flip_pending <= 1'b0;
      core.inst    <= IDLE_INST;
      core.sel     <= 1'b0;
      core.mode    <= 1'b0;
      core.relu    <= 1'b0;
      core.tile    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      core.inst <= inst_nxt;
      done      <= 1'b0;
      // Bank flips one cycle after the final write so sel stays aligned
      // with every write of the kernel position.
      if (flip_pending) begin
        core.sel     <= ~core.sel;
        flip_pending <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start && !busy) begin
            w_base_r  <= cfg_w_base;
            x_base_r  <= cfg_x_base;
            p_base_r  <= cfg_p_base;
            nij_r     <= cfg_nij;
            kij_r     <= cfg_kij;
            core.tile <= cfg_tile;
            core.mode <= cfg_mode;
            core.relu <= cfg_relu;
            core.sel  <= cfg_sel0;
            kij_cnt   <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= S_WFILL;
          end
        end
        S_WFILL: begin
          if (cnt == FILL_LAST) begin
            cnt   <= '0;
            state <= S_WLOAD;
          end else cnt <= cnt + 1'b1;
        end
        S_WLOAD: begin
          if (cnt == WAVE_LAST) begin
            cnt   <= '0;
            state <= S_WGAP;
          end else cnt <= cnt + 1'b1;
        end
        S_WGAP: begin
          if (cnt == WAVE_LAST) begin
            cnt   <= '0;
            state <= S_XEXEC;
          end else cnt <= cnt + 1'b1;
        end
        S_XEXEC: begin
          if (cnt == exec_last) begin
            cnt   <= '0;
            state <= S_DRAIN;
          end else cnt <= cnt + 1'b1;
        end
        S_DRAIN: begin
          if (core.ofifo_valid) begin
            if (last_write) begin
              cnt          <= '0;
              flip_pending <= 1'b1;
              if (last_kij) state <= S_DONE;
              else begin
                kij_cnt <= kij_cnt + 1'b1;
                state   <= S_WFILL;
              end
            end else cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
